// File: rtl/tron_pkg.sv
// Shared types and helpers for the light-cycle engine: direction encoding,
// dir_req bit positions, reverse-direction lookup and default colours.
package tron_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_UP    = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int REQ_RIGHT = 0;
    localparam int REQ_UP    = 1;
    localparam int REQ_DOWN  = 2;
    localparam int REQ_LEFT  = 3;

    localparam logic [2:0] COL_WALL        = 3'b111;
    localparam logic [2:0] COL_BLANK       = 3'b000;
    localparam logic [5:0] DEF_PLAYER_COLS = 6'b100_001;

    function automatic dir_t reverse_dir(input dir_t d);
        case (d)
            DIR_RIGHT: return DIR_LEFT;
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_LEFT;
        endcase
    endfunction

    function automatic logic req_onehot(input logic [3:0] r);
        return (r != 4'd0) && ((r & (r - 4'd1)) == 4'd0);
    endfunction

    function automatic dir_t req_to_dir(input logic [3:0] r);
        dir_t d;
        if (r[REQ_RIGHT]) d = DIR_RIGHT;
        else if (r[REQ_UP]) d = DIR_UP;
        else if (r[REQ_DOWN]) d = DIR_DOWN;
        else if (r[REQ_LEFT]) d = DIR_LEFT;
        else d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/tron_occupancy_ram.sv
// Single-port 1-bit occupancy map of the play field; synchronous read with
// write-first behaviour, one cycle of read latency.
module tron_occupancy_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          wdata,
    output logic          rdata
);

    logic mem [DEPTH];

    // Occupancy storage; a write returns the new value on the read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/tron_arena.sv
// N-player light-cycle engine: clears the field, places players, then moves
// every live player per step tick, detecting wall/trail hits and issuing plots.
module tron_arena import tron_pkg::*; #(
    parameter int NUM_PLAYERS = 2,
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int X_LO  = 10,
    parameter int X_HI  = 149,
    parameter int Y_LO  = 17,
    parameter int Y_HI  = 108,
    parameter logic [NUM_PLAYERS*X_W-1:0] START_X    = {8'd100, 8'd25},
    parameter logic [NUM_PLAYERS*Y_W-1:0] START_Y    = {7'd100, 7'd100},
    parameter logic [NUM_PLAYERS*2-1:0]   START_DIR  = {2'd3, 2'd0},
    parameter logic [NUM_PLAYERS*3-1:0]   PLAYER_COL = DEF_PLAYER_COLS,
    parameter logic [2:0]                 WALL_COL   = COL_WALL
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     go,
    input  logic                     step,
    input  logic [4*NUM_PLAYERS-1:0] dir_req,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [2:0]               colour,
    output logic                     plot,
    output logic [NUM_PLAYERS-1:0]   alive,
    output logic                     game_over,
    output logic [1:0]               winner,
    output logic                     winner_valid
);

    localparam int DEPTH = SCR_W * SCR_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_PLAYERS - 1);

    localparam logic [3:0] S_CLEAR    = 4'd0;
    localparam logic [3:0] S_PLACE    = 4'd1;
    localparam logic [3:0] S_IDLE     = 4'd2;
    localparam logic [3:0] S_RUN_WAIT = 4'd3;
    localparam logic [3:0] S_READ     = 4'd4;
    localparam logic [3:0] S_CHECK    = 4'd5;
    localparam logic [3:0] S_WRITE    = 4'd6;
    localparam logic [3:0] S_EVAL     = 4'd7;
    localparam logic [3:0] S_OVER     = 4'd8;

    logic [3:0]     state;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [IW-1:0]  idx;
    logic           pending;
    logic [X_W-1:0] pos_x [NUM_PLAYERS];
    logic [Y_W-1:0] pos_y [NUM_PLAYERS];
    dir_t           cur_dir [NUM_PLAYERS];
    dir_t           next_dir [NUM_PLAYERS];
    logic [X_W-1:0] nxt_x;
    logic [Y_W-1:0] nxt_y;

    logic [X_W-1:0] step_x;
    logic [Y_W-1:0] step_y;
    logic           is_wall;
    logic           in_move;
    logic           reload;
    logic [2:0]     live_cnt;
    logic [1:0]     lone_idx;
    logic           game_end;
    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic           ram_wdata;
    logic           ram_rdata;

    function automatic logic [AW-1:0] addr_of(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        return AW'(py) * AW'(SCR_W) + AW'(px);
    endfunction

    assign is_wall = (((cx == X_W'(X_LO)) || (cx == X_W'(X_HI))) && (cy >= Y_W'(Y_LO)) && (cy <= Y_W'(Y_HI)))
                  || (((cy == Y_W'(Y_LO)) || (cy == Y_W'(Y_HI))) && (cx >= X_W'(X_LO)) && (cx <= X_W'(X_HI)));
    assign in_move  = (state == S_READ) || (state == S_CHECK) || (state == S_WRITE) || (state == S_EVAL);
    assign reload   = (state == S_OVER) && go;
    assign game_end = (NUM_PLAYERS > 1) ? (live_cnt <= 3'd1) : (live_cnt == 3'd0);

    // Candidate cell for the player being read, using its pending direction.
    always_comb begin
        step_x = pos_x[idx];
        step_y = pos_y[idx];
        case (next_dir[idx])
            DIR_RIGHT: step_x = pos_x[idx] + X_W'(1);
            DIR_LEFT:  step_x = pos_x[idx] - X_W'(1);
            DIR_UP:    step_y = pos_y[idx] - Y_W'(1);
            DIR_DOWN:  step_y = pos_y[idx] + Y_W'(1);
            default:   step_x = pos_x[idx];
        endcase
    end

    // Survivor count and the index of the last live player found.
    always_comb begin
        live_cnt = 3'd0;
        lone_idx = 2'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive[i]) begin
                live_cnt = live_cnt + 3'd1;
                lone_idx = 2'(i);
            end else begin
                live_cnt = live_cnt;
            end
        end
    end

    // Occupancy RAM port steering per state.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 1'b0;
        case (state)
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = addr_of(cx, cy);
                ram_wdata = is_wall;
            end
            S_PLACE: begin
                ram_we    = 1'b1;
                ram_addr  = addr_of(pos_x[idx], pos_y[idx]);
                ram_wdata = 1'b1;
            end
            S_READ:  ram_addr = addr_of(step_x, step_y);
            S_WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = addr_of(nxt_x, nxt_y);
                ram_wdata = 1'b1;
            end
            default: ram_we = 1'b0;
        endcase
    end

    tron_occupancy_ram #(.DEPTH(DEPTH), .AW(AW)) u_occ (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Steering: keep the latest legal request; reverses and non-one-hot are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PLAYERS; i++) next_dir[i] <= dir_t'(START_DIR[i*2 +: 2]);
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (reload) begin
                    next_dir[i] <= dir_t'(START_DIR[i*2 +: 2]);
                end else if (req_onehot(dir_req[i*4 +: 4]) &&
                             (req_to_dir(dir_req[i*4 +: 4]) != reverse_dir(cur_dir[i]))) begin
                    next_dir[i] <= req_to_dir(dir_req[i*4 +: 4]);
                end else begin
                    next_dir[i] <= next_dir[i];
                end
            end
        end
    end

    // Main sequencer: clear sweep, placement, per-player moves and round result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_CLEAR;
            cx           <= '0;
            cy           <= '0;
            idx          <= '0;
            pending      <= 1'b0;
            alive        <= '0;
            nxt_x        <= '0;
            nxt_y        <= '0;
            x            <= '0;
            y            <= '0;
            colour       <= 3'd0;
            plot         <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_x[i]   <= START_X[i*X_W +: X_W];
                pos_y[i]   <= START_Y[i*Y_W +: Y_W];
                cur_dir[i] <= dir_t'(START_DIR[i*2 +: 2]);
            end
        end else begin
            plot <= 1'b0;
            if (in_move && step) pending <= 1'b1;
            case (state)
                S_CLEAR: begin
                    plot   <= 1'b1;
                    x      <= cx;
                    y      <= cy;
                    colour <= is_wall ? WALL_COL : COL_BLANK;
                    if (cx == X_W'(SCR_W - 1)) begin
                        cx <= '0;
                        if (cy == Y_W'(SCR_H - 1)) begin
                            cy    <= '0;
                            idx   <= '0;
                            state <= S_PLACE;
                        end else begin
                            cy <= cy + Y_W'(1);
                        end
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                S_PLACE: begin
                    plot       <= 1'b1;
                    x          <= pos_x[idx];
                    y          <= pos_y[idx];
                    colour     <= PLAYER_COL[int'(idx)*3 +: 3];
                    alive[idx] <= 1'b1;
                    if (idx == LAST) state <= S_IDLE;
                    else idx <= idx + IW'(1);
                end
                S_IDLE: if (go) state <= S_RUN_WAIT;
                S_RUN_WAIT: begin
                    if (step || pending) begin
                        pending <= 1'b0;
                        idx     <= '0;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (alive[idx]) begin
                        cur_dir[idx] <= next_dir[idx];
                        nxt_x        <= step_x;
                        nxt_y        <= step_y;
                        state        <= S_CHECK;
                    end else if (idx == LAST) begin
                        state <= S_EVAL;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_CHECK: begin
                    if (!ram_rdata) begin
                        state <= S_WRITE;
                    end else begin
                        alive[idx] <= 1'b0;
                        if (idx == LAST) state <= S_EVAL;
                        else begin
                            idx   <= idx + IW'(1);
                            state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    pos_x[idx] <= nxt_x;
                    pos_y[idx] <= nxt_y;
                    plot       <= 1'b1;
                    x          <= nxt_x;
                    y          <= nxt_y;
                    colour     <= PLAYER_COL[int'(idx)*3 +: 3];
                    if (idx == LAST) state <= S_EVAL;
                    else begin
                        idx   <= idx + IW'(1);
                        state <= S_READ;
                    end
                end
                S_EVAL: begin
                    if (game_end) begin
                        state        <= S_OVER;
                        game_over    <= 1'b1;
                        winner_valid <= (live_cnt == 3'd1);
                        winner       <= (live_cnt == 3'd1) ? lone_idx : 2'd0;
                    end else begin
                        state <= S_RUN_WAIT;
                    end
                end
                S_OVER: begin
                    if (go) begin
                        state        <= S_CLEAR;
                        cx           <= '0;
                        cy           <= '0;
                        idx          <= '0;
                        pending      <= 1'b0;
                        alive        <= '0;
                        game_over    <= 1'b0;
                        winner       <= 2'd0;
                        winner_valid <= 1'b0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            pos_x[i]   <= START_X[i*X_W +: X_W];
                            pos_y[i]   <= START_Y[i*Y_W +: Y_W];
                            cur_dir[i] <= dir_t'(START_DIR[i*2 +: 2]);
                        end
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_tron_arena.sv
// Scoreboard bench for tron_arena: expected plots are queued as stimulus is
// issued and a negedge monitor pops and compares every DUT plot.
module tb_tron_arena;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } plot_t;

    logic       clk = 1'b0;
    logic       resetn, go, step, go2, step2;
    logic [7:0] dir_req, dir_req2;
    logic [7:0] x, x2;
    logic [6:0] y, y2;
    logic [2:0] colour, colour2;
    logic       plot, plot2, game_over, game_over2, winner_valid, winner_valid2;
    logic [1:0] alive, alive2, winner, winner2;

    int total = 0;
    int bad   = 0;
    plot_t exp_q[$];

    int  mx[2], my[2], md[2], mnd[2];
    bit  malive[2];
    bit  occ [0:159][0:119];
    int  last2_x, last2_y, last2_c;

    always #5 clk = ~clk;

    tron_arena dut (
        .clk(clk), .resetn(resetn), .go(go), .step(step), .dir_req(dir_req),
        .x(x), .y(y), .colour(colour), .plot(plot), .alive(alive),
        .game_over(game_over), .winner(winner), .winner_valid(winner_valid)
    );

    tron_arena #(.START_X({8'd99, 8'd25})) dut2 (
        .clk(clk), .resetn(resetn), .go(go2), .step(step2), .dir_req(dir_req2),
        .x(x2), .y(y2), .colour(colour2), .plot(plot2), .alive(alive2),
        .game_over(game_over2), .winner(winner2), .winner_valid(winner_valid2)
    );

    function automatic void model_clear();
        int sx[2];
        int sd[2];
        int pcol[2];
        bit w;
        sx = '{25, 100};
        sd = '{0, 3};
        pcol = '{1, 4};
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                w = ((xx == 10 || xx == 149) && yy >= 17 && yy <= 108) ||
                    ((yy == 17 || yy == 108) && xx >= 10 && xx <= 149);
                occ[xx][yy] = w;
                exp_q.push_back({8'(xx), 7'(yy), w ? 3'd7 : 3'd0});
            end
        end
        for (int i = 0; i < 2; i++) begin
            mx[i] = sx[i]; my[i] = 100; md[i] = sd[i]; mnd[i] = sd[i];
            malive[i] = 1'b1;
            occ[mx[i]][my[i]] = 1'b1;
            exp_q.push_back({8'(mx[i]), 7'(my[i]), 3'(pcol[i])});
        end
    endfunction

    function automatic void model_req(input logic [7:0] vec);
        logic [3:0] r;
        int d;
        for (int i = 0; i < 2; i++) begin
            r = vec[i*4 +: 4];
            if ($countones(r) == 1) begin
                d = r[0] ? 0 : r[1] ? 1 : r[2] ? 2 : 3;
                if (d != 3 - md[i]) mnd[i] = d;
            end
        end
    endfunction

    function automatic void model_step();
        int pcol[2];
        int nx, ny;
        pcol = '{1, 4};
        for (int i = 0; i < 2; i++) begin
            if (malive[i]) begin
                md[i] = mnd[i];
                nx = mx[i] + ((md[i] == 0) ? 1 : (md[i] == 3) ? -1 : 0);
                ny = my[i] + ((md[i] == 2) ? 1 : (md[i] == 1) ? -1 : 0);
                if (occ[nx][ny]) malive[i] = 1'b0;
                else begin
                    occ[nx][ny] = 1'b1;
                    mx[i] = nx; my[i] = ny;
                    exp_q.push_back({8'(nx), 7'(ny), 3'(pcol[i])});
                end
            end
        end
    endfunction

    // Plot monitor: every DUT write must match the head of the expectation queue.
    always @(negedge clk) begin
        plot_t e;
        if (resetn === 1'b1 && plot === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL plot: unexpected (%0d,%0d) colour %0d, want no plot", x, y, colour);
            end else begin
                e = exp_q.pop_front();
                if (e != {x, y, colour}) begin
                    bad++;
                    $display("FAIL plot: got (%0d,%0d) colour %0d want (%0d,%0d) colour %0d",
                             x, y, colour, e.px, e.py, e.pc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (plot2 === 1'b1) begin
            last2_x = int'(x2); last2_y = int'(y2); last2_c = int'(colour2);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d plots outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        cyc(5);
    endtask

    task automatic tick(input logic [7:0] vec);
        dir_req = vec;
        cyc(1);
        dir_req = 8'h00;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        model_req(vec);
        model_step();
        cyc(10);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vec;
        resetn = 1'b0; go = 1'b0; step = 1'b0; dir_req = 8'h00;
        go2 = 1'b0; step2 = 1'b0; dir_req2 = 8'h00;
        model_clear();
        cyc(3);
        chk("rst_plot", int'(plot), 0);
        chk("rst_alive", int'(alive), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_xyc", int'({x, y, colour}), 0);
        chk("rst_winner", int'({winner_valid, winner}), 0);
        resetn = 1'b1;
        drain(20000);
        chk("place_alive", int'(alive), 3);
        chk("place_game_over", int'(game_over), 0);

        go = 1'b1;
        cyc(3);
        go = 1'b0;
        tick(8'h00); tick(8'h00); tick(8'h00);
        tick(8'h08);
        tick(8'h02);
        drain(20);

        // P0 runs right into the wall while P1 loops clear of it.
        for (int t = 1; t <= 200 && malive[0] && malive[1]; t++) begin
            vec = (t == 1) ? 8'h41 : (t == 4) ? 8'h80 : (t == 87) ? 8'h20 : 8'h00;
            tick(vec);
        end
        drain(20);
        chk("wall_game_over", int'(game_over), 1);
        chk("wall_winner", int'(winner), 1);
        chk("wall_winner_valid", int'(winner_valid), 1);
        chk("wall_alive", int'(alive), 2);

        model_clear();
        go = 1'b1;
        drain(20000);
        go = 1'b0;
        chk("r2_game_over", int'(game_over), 0);
        chk("r2_alive", int'(alive), 3);

        step = 1'b1; cyc(1); step = 1'b0;
        model_step();
        model_step();
        cyc(1);
        step = 1'b1; cyc(1);
        cyc(1); step = 1'b0;
        cyc(30);
        drain(10);

        step = 1'b1; cyc(1); step = 1'b0;
        cyc(1);
        resetn = 1'b0;
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_alive", int'(alive), 0);
        model_clear();
        cyc(2);
        resetn = 1'b1;
        drain(20000);
        chk("reclear_alive", int'(alive), 3);

        go2 = 1'b1;
        cyc(3);
        go2 = 1'b0;
        for (int t = 0; t < 40; t++) begin
            step2 = 1'b1; cyc(1); step2 = 1'b0;
            cyc(10);
        end
        chk("headon_game_over", int'(game_over2), 1);
        chk("headon_winner", int'(winner2), 0);
        chk("headon_winner_valid", int'(winner_valid2), 1);
        chk("headon_alive", int'(alive2), 1);
        chk("headon_last_x", last2_x, 62);
        chk("headon_last_y", last2_y, 100);
        chk("headon_last_colour", last2_c, 1);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
